adu_stream: RTL and testbench



---
 rtl/adu_pkg.sv | 21 ++
 rtl/adu_lane_mux.sv | 31 +++
 rtl/adu_stream.sv | 147 ++++++++++++++
 tb/tb_adu_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adu_pkg.sv
// Shared definitions for the address unit: FSM encoding and lane extraction.
// The extraction helper works on a wide carrier vector so any AW/DW pairing can reuse it.
package adu_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } adu_state_e;

    // Widest address the lane helper can carry; callers zero-extend into it.
    localparam int ADU_MAX_W = 1024;

    function automatic logic [ADU_MAX_W-1:0] lane_of(
        input logic [ADU_MAX_W-1:0] word,
        input int unsigned          idx,
        input int unsigned          dw
    );
        return (word >> (idx * dw)) & ((ADU_MAX_W'(1) << dw) - ADU_MAX_W'(1));
    endfunction

endpackage

// File: rtl/adu_lane_mux.sv
// NB:1 byte-lane selector over an AW-bit word. Out-of-range indices read as zero.
module adu_lane_mux
    import adu_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int NB = AW / DW,
    parameter int LW = 1
) (
    input  logic [AW-1:0] word,
    input  logic [LW-1:0] idx,
    output logic [DW-1:0] y
);

    logic [DW-1:0]        lanes [2**LW];
    logic [ADU_MAX_W-1:0] word_ext;

    assign word_ext = ADU_MAX_W'(word);

    // Pad the table up to a power of two so every idx value selects a defined entry.
    for (genvar gi = 0; gi < 2**LW; gi++) begin : g_lane
        if (gi < NB) begin : g_real
            assign lanes[gi] = DW'(lane_of(word_ext, gi, DW));
        end else begin : g_pad
            assign lanes[gi] = '0;
        end
    end

    assign y = lanes[idx];

endmodule

// File: rtl/adu_stream.sv
// Address register with per-lane load, inc/dec with wrap flag, single-lane readout
// and a lane-by-lane burst serializer onto a DW-bit tri-state bus.
module adu_stream
    import adu_pkg::*;
#(
    parameter  int AW        = 16,
    parameter  int DW        = 8,
    parameter  int STEP      = 1,
    parameter  int MSB_FIRST = 0,
    localparam int NB        = AW / DW,
    localparam int LW        = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a,
    input  logic          we,
    input  logic [DW-1:0] d,
    input  logic          ld_lane,
    input  logic [LW-1:0] lane_sel,
    input  logic          inc,
    input  logic          dec,
    input  logic          rd,
    input  logic          oe,
    output wire  [DW-1:0] q,
    output logic          q_valid,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic [AW-1:0] addr
);

    localparam logic [LW-1:0] LAST     = LW'(NB - 1);
    localparam logic [AW:0]   STEP_EXT = (AW + 1)'(STEP);

    adu_state_e    state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] out_reg, out_next;
    logic [LW-1:0] cnt_reg, cnt_next;
    logic          q_valid_reg, q_valid_next;
    logic          done_reg, done_next;
    logic          wrap_reg, wrap_next;

    logic [LW-1:0] beat_idx;
    logic [LW-1:0] mux_idx;
    logic [DW-1:0] lane_y;
    logic [AW:0]   sum;
    logic [AW:0]   diff;

    // Beat about to be presented: 0 when a burst starts, otherwise the one after cnt_reg.
    always_comb begin
        beat_idx = (state_reg == IDLE) ? '0 : cnt_reg + 1'b1;
        if ((state_reg == BURST) || rd) begin
            mux_idx = (MSB_FIRST != 0) ? LAST - beat_idx : beat_idx;
        end else begin
            mux_idx = lane_sel;
        end
    end

    adu_lane_mux #(
        .AW (AW),
        .DW (DW),
        .NB (NB),
        .LW (LW)
    ) u_lane_mux (
        .word (addr_reg),
        .idx  (mux_idx),
        .y    (lane_y)
    );

    assign sum  = {1'b0, addr_reg} + STEP_EXT;
    assign diff = {1'b0, addr_reg} - STEP_EXT;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        out_next     = out_reg;
        cnt_next     = cnt_reg;
        q_valid_next = 1'b0;
        done_next    = 1'b0;
        wrap_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Readout samples the address before any update on this edge.
                out_next = lane_y;
                if (rd) begin
                    state_next   = BURST;
                    cnt_next     = '0;
                    q_valid_next = 1'b1;
                    done_next    = (NB == 1);
                end else if (we) begin
                    addr_next = a;
                end else if (ld_lane) begin
                    for (int i = 0; i < NB; i++) begin
                        if (int'(lane_sel) == i) begin
                            addr_next[i*DW +: DW] = d;
                        end
                    end
                end else if (inc && !dec) begin
                    addr_next = sum[AW-1:0];
                    wrap_next = sum[AW];
                end else if (dec && !inc) begin
                    addr_next = diff[AW-1:0];
                    wrap_next = diff[AW];
                end
            end
            BURST: begin
                if (cnt_reg == LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next     = cnt_reg + 1'b1;
                    out_next     = lane_y;
                    q_valid_next = 1'b1;
                    done_next    = (cnt_next == LAST);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            out_reg     <= '0;
            cnt_reg     <= '0;
            q_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            out_reg     <= out_next;
            cnt_reg     <= cnt_next;
            q_valid_reg <= q_valid_next;
            done_reg    <= done_next;
            wrap_reg    <= wrap_next;
        end
    end

    assign q       = oe ? out_reg : {DW{1'bz}};
    assign q_valid = q_valid_reg;
    assign busy    = q_valid_reg;
    assign done    = done_reg;
    assign wrap    = wrap_reg;
    assign addr    = addr_reg;

endmodule

// File: tb/tb_adu_stream.sv
// Scoreboard bench for adu_stream: four configurations share one stimulus stream and a
// behavioural model pushes per-cycle expectations that a monitor pops and compares.
module tb_adu_stream;

    localparam int NI = 4;

    typedef struct {
        int              k;
        longint unsigned addr;
        bit              wrap;
        bit              valid;
        bit              done;
        logic [7:0]      q;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, we, ld_lane, inc, dec, rd, oe;
    logic [31:0] a32;
    logic [7:0]  d;
    logic [1:0]  sel;

    wire  [7:0]  q0, q1, q2, q3;
    logic        v0, v1, v2, v3, b0, b1, b2, b3, dn0, dn1, dn2, dn3, w0, w1, w2, w3;
    logic [15:0] addr0, addr1;
    logic [31:0] addr2;
    logic [23:0] addr3;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        expq[$];

    int              aw_k  [NI] = '{16, 16, 32, 24};
    int              msb_k [NI] = '{0, 1, 0, 0};
    longint unsigned m_addr[NI];
    longint unsigned m_snap[NI];
    logic [7:0]      m_out [NI];
    int              m_beat[NI];

    always #5 clk = ~clk;

    // Released bus reads as all ones so a floating q is observable.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup pu0 (q0[gi]);
        pullup pu1 (q1[gi]);
        pullup pu2 (q2[gi]);
        pullup pu3 (q3[gi]);
    end

    adu_stream #(.AW(16), .DW(8), .STEP(1), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .a(a32[15:0]), .we(we), .d(d), .ld_lane(ld_lane),
        .lane_sel(sel[0]), .inc(inc), .dec(dec), .rd(rd), .oe(oe), .q(q0),
        .q_valid(v0), .busy(b0), .done(dn0), .wrap(w0), .addr(addr0));
    adu_stream #(.AW(16), .DW(8), .STEP(1), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .a(a32[15:0]), .we(we), .d(d), .ld_lane(ld_lane),
        .lane_sel(sel[0]), .inc(inc), .dec(dec), .rd(rd), .oe(oe), .q(q1),
        .q_valid(v1), .busy(b1), .done(dn1), .wrap(w1), .addr(addr1));
    adu_stream #(.AW(32), .DW(8), .STEP(1), .MSB_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .a(a32), .we(we), .d(d), .ld_lane(ld_lane),
        .lane_sel(sel), .inc(inc), .dec(dec), .rd(rd), .oe(oe), .q(q2),
        .q_valid(v2), .busy(b2), .done(dn2), .wrap(w2), .addr(addr2));
    adu_stream #(.AW(24), .DW(8), .STEP(1), .MSB_FIRST(0)) dut3 (
        .clk(clk), .rst(rst), .a(a32[23:0]), .we(we), .d(d), .ld_lane(ld_lane),
        .lane_sel(sel), .inc(inc), .dec(dec), .rd(rd), .oe(oe), .q(q3),
        .q_valid(v3), .busy(b3), .done(dn3), .wrap(w3), .addr(addr3));

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] lane_at(input int k, input longint unsigned v, input int j);
        int nb  = aw_k[k] / 8;
        int idx = (msb_k[k] != 0) ? nb - 1 - j : j;
        return 8'(v >> (8 * idx));
    endfunction

    // Reference behaviour for one instance across the coming clock edge.
    task automatic model_step(input int k);
        exp_t            e;
        int              nb   = aw_k[k] / 8;
        longint unsigned mask = (64'd1 << aw_k[k]) - 64'd1;
        int              s    = (k < 2) ? int'(sel[0]) : int'(sel);
        e.k = k; e.wrap = 1'b0; e.valid = 1'b0; e.done = 1'b0;
        if (rst) begin
            m_addr[k] = 0; m_out[k] = 8'h00; m_beat[k] = -1;
        end else if (m_beat[k] >= 0) begin
            m_beat[k]++;
            if (m_beat[k] < nb) begin
                m_out[k] = lane_at(k, m_snap[k], m_beat[k]);
                e.valid  = 1'b1;
                e.done   = (m_beat[k] == nb - 1);
            end else begin
                m_beat[k] = -1;
            end
        end else if (rd) begin
            m_snap[k] = m_addr[k];
            m_beat[k] = 0;
            m_out[k]  = lane_at(k, m_snap[k], 0);
            e.valid   = 1'b1;
            e.done    = (nb == 1);
        end else begin
            m_out[k] = (s < nb) ? 8'(m_addr[k] >> (8 * s)) : 8'h00;
            if (we) begin
                m_addr[k] = longint'(a32) & mask;
            end else if (ld_lane) begin
                if (s < nb)
                    m_addr[k] = (m_addr[k] & ~(64'hFF << (8 * s))) | (longint'(d) << (8 * s));
            end else if (inc && !dec) begin
                m_addr[k] = m_addr[k] + 1;
                e.wrap    = (m_addr[k] > mask);
                m_addr[k] = m_addr[k] & mask;
            end else if (dec && !inc) begin
                e.wrap    = (m_addr[k] == 0);
                m_addr[k] = (m_addr[k] - 1) & mask;
            end
        end
        e.addr = m_addr[k];
        e.q    = oe ? m_out[k] : 8'hFF;
        expq.push_back(e);
    endtask

    task automatic tick();
        for (int k = 0; k < NI; k++) model_step(k);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0; ld_lane = 1'b0; inc = 1'b0; dec = 1'b0; rd = 1'b0;
    endtask

    // Monitor: one expectation per instance per clock edge.
    initial begin
        exp_t            e;
        longint unsigned a_act;
        logic [7:0]      q_act;
        logic            v_act, b_act, d_act, w_act;
        forever begin
            @(posedge clk);
            #1;
            while (expq.size() > 0) begin
                e = expq.pop_front();
                case (e.k)
                    0:       begin a_act = addr0; q_act = q0; v_act = v0; b_act = b0; d_act = dn0; w_act = w0; end
                    1:       begin a_act = addr1; q_act = q1; v_act = v1; b_act = b1; d_act = dn1; w_act = w1; end
                    2:       begin a_act = addr2; q_act = q2; v_act = v2; b_act = b2; d_act = dn2; w_act = w2; end
                    default: begin a_act = addr3; q_act = q3; v_act = v3; b_act = b3; d_act = dn3; w_act = w3; end
                endcase
                check($sformatf("dut%0d.addr", e.k),    a_act, e.addr);
                check($sformatf("dut%0d.wrap", e.k),    w_act, e.wrap);
                check($sformatf("dut%0d.q_valid", e.k), v_act, e.valid);
                check($sformatf("dut%0d.busy", e.k),    b_act, e.valid);
                check($sformatf("dut%0d.done", e.k),    d_act, e.done);
                check($sformatf("dut%0d.q", e.k),       q_act, e.q);
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; ld_lane = 1'b0; inc = 1'b0; dec = 1'b0; rd = 1'b0; oe = 1'b1;
        a32 = '0; d = '0; sel = '0;
        for (int k = 0; k < NI; k++) begin
            m_addr[k] = 0; m_snap[k] = 0; m_out[k] = 8'h00; m_beat[k] = -1;
        end
        @(negedge clk);
        rst = 1'b1; tick();
        rst = 1'b1; tick();

        // Load and single-lane readout, then release the bus.
        we = 1'b1; a32 = 32'hDEAD_7A0E; tick();
        sel = 2'd0; tick();
        sel = 2'd1; tick();
        sel = 2'd3; tick();
        oe = 1'b0;
        #1;
        check("oe_z_same_cycle", q0, 8'hFF);
        tick();
        oe = 1'b1;

        // Plain burst on 0x4E20 (32-bit instance sees 0x00004E20).
        we = 1'b1; a32 = 32'h0000_4E20; tick();
        rd = 1'b1; tick();
        repeat (5) tick();

        // Wrap on increment and decrement; simultaneous inc/dec holds.
        we = 1'b1; a32 = 32'hFFFF_FFFF; tick();
        inc = 1'b1; tick();
        dec = 1'b1; tick();
        inc = 1'b1; dec = 1'b1; tick();

        // Lane load, and full load beating lane load on the same edge.
        we = 1'b1; a32 = 32'h0000_4E20; tick();
        ld_lane = 1'b1; sel = 2'd1; d = 8'hAB; tick();
        ld_lane = 1'b1; sel = 2'd2; d = 8'h5C; tick();
        we = 1'b1; a32 = 32'h0000_1234; ld_lane = 1'b1; sel = 2'd0; d = 8'hCD; tick();

        // Reset on the first beat; then address requests during a burst are ignored.
        we = 1'b1; a32 = 32'h0000_7A0E; tick();
        rd = 1'b1; tick();
        rst = 1'b1; tick();
        tick();
        we = 1'b1; a32 = 32'h0000_7A0E; tick();
        rd = 1'b1; tick();
        we = 1'b1; a32 = 32'h0000_1111; inc = 1'b1; tick();
        inc = 1'b1; tick();
        repeat (3) tick();

        // Long burst with rd held throughout.
        we = 1'b1; a32 = 32'hDEAD_BEEF; tick();
        for (int i = 0; i < 6; i++) begin
            rd = 1'b1; tick();
        end
        repeat (3) tick();

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            rd      = ($urandom_range(0, 7) == 0);
            we      = ($urandom_range(0, 5) == 0);
            ld_lane = ($urandom_range(0, 5) == 0);
            inc     = ($urandom_range(0, 2) == 0);
            dec     = ($urandom_range(0, 2) == 0);
            oe      = ($urandom_range(0, 3) != 0);
            a32     = $urandom;
            d       = 8'($urandom);
            sel     = 2'($urandom);
            if ($urandom_range(0, 15) == 0) a32 = 32'hFFFF_FFFF;
            tick();
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
